pipe_seq: RTL

- Pipeline sequencer for the 16-bit two-stage RISC core.
- Owns the PC register and the stage-1/stage-2 instruction register write/flush strobes.
- Consumes the stage-2 decode results: taken-branch/call/return redirect, halt, and data-memory access.
- Stalls both stages on a data-memory handshake; raises a sticky fault on handshake timeout.

---
 rtl/pipe_seq_if.sv | 28 ++
 rtl/pipe_seq.sv | 112 +++++++++++
 2 files changed

// File: rtl/pipe_seq_if.sv
// Sequencer <-> core bundle: stage-2 decode results and dmem ack in, PC/IR strobes/status out.
interface pipe_seq_if;
  logic        run;
  logic        pc_load_s2;
  logic [15:0] pc_target_s2;
  logic        hlt_s2;
  logic        mem_op_s2;
  logic        dmem_ack;
  logic [15:0] pc;
  logic        ir1_we;
  logic        ir2_we;
  logic        ir1_flush;
  logic        ir2_flush;
  logic        dmem_req;
  logic        halted;
  logic        fault;
  logic [2:0]  state;

  modport master (
    input  run, pc_load_s2, pc_target_s2, hlt_s2, mem_op_s2, dmem_ack,
    output pc, ir1_we, ir2_we, ir1_flush, ir2_flush, dmem_req, halted, fault, state
  );

  modport slave (
    output run, pc_load_s2, pc_target_s2, hlt_s2, mem_op_s2, dmem_ack,
    input  pc, ir1_we, ir2_we, ir1_flush, ir2_flush, dmem_req, halted, fault, state
  );
endinterface

// File: rtl/pipe_seq.sv
// Pipeline sequencer for the 16-bit two-stage core: PC, IR strobes, dmem stall/timeout.
module pipe_seq #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       rst,
  pipe_seq_if.master bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RUN     = 3'd1;
  localparam logic [2:0] MEMWAIT = 3'd2;
  localparam logic [2:0] HALT    = 3'd3;
  localparam logic [2:0] FAULT   = 3'd4;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [2:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;
  logic        advance;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    cnt_d         = cnt_q;
    halted_d      = halted_q;
    fault_d       = fault_q;
    advance       = 1'b0;
    bus.ir1_we    = 1'b0;
    bus.ir2_we    = 1'b0;
    bus.ir1_flush = 1'b0;
    bus.ir2_flush = 1'b0;
    bus.dmem_req  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.run) state_d = RUN;
      end
      RUN: begin
        if (bus.hlt_s2) begin
          bus.ir1_flush = 1'b1;
          bus.ir2_flush = 1'b1;
          halted_d      = 1'b1;
          state_d       = HALT;
        end else if (bus.mem_op_s2 && !bus.dmem_ack) begin
          bus.dmem_req = 1'b1;
          cnt_d        = 8'd1;
          state_d      = MEMWAIT;
        end else begin
          bus.dmem_req = bus.mem_op_s2;
          advance      = 1'b1;
        end
      end
      MEMWAIT: begin
        bus.dmem_req = 1'b1;
        // An ack in the timeout cycle still completes the access.
        if (bus.dmem_ack) begin
          advance = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end else if (cnt_q == TIMEOUT_C) begin
          fault_d  = 1'b1;
          halted_d = 1'b1;
          state_d  = FAULT;
        end else begin
          cnt_d = 8'(cnt_q + 8'd1);
        end
      end
      HALT, FAULT: ;
      default: state_d = IDLE;
    endcase

    // Shared advance/redirect action for RUN and the MEMWAIT ack cycle.
    if (advance) begin
      bus.ir1_we = 1'b1;
      bus.ir2_we = 1'b1;
      if (bus.pc_load_s2) begin
        pc_d          = bus.pc_target_s2;
        bus.ir1_flush = 1'b1;
        bus.ir2_flush = 1'b1;
      end else begin
        pc_d = 16'(pc_q + 16'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.pc     = pc_q;
  assign bus.state  = state_q;
  assign bus.halted = halted_q;
  assign bus.fault  = fault_q;

endmodule
